// File: rtl/tetris_pkg.sv
// Shared Tetris datapath definitions: board geometry, cell layout, row-clear
// FSM encoding and row helpers used by the writer and the display side.
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int CELL_W  = 4;
  localparam int ROW_W   = COLS * CELL_W;
  localparam int BOARD_W = ROWS * ROW_W;

  localparam int IDX_W   = 5;
  localparam int LINES_W = 5;
  localparam int SCORE_W = 14;

  // Cell bit-field offsets: occupied flag followed by the colour bits.
  localparam int OCC = 0;
  localparam int C2  = 1;
  localparam int C1  = 2;
  localparam int C0  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } rce_state_t;

  // Lowest bit index of row r inside the flat board vector.
  function automatic logic [9:0] row_slice(input logic [IDX_W-1:0] r);
    return 10'(r) * 10'(ROW_W);
  endfunction

  // A row is full when every cell's occupied bit is set; colour is ignored.
  function automatic logic row_full(input logic [ROW_W-1:0] row);
    logic f;
    f = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      f = f & row[c*CELL_W + OCC];
    end
    return f;
  endfunction

  // True when any cell of the row is occupied.
  function automatic logic row_any(input logic [ROW_W-1:0] row);
    logic a;
    a = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      a = a | row[c*CELL_W + OCC];
    end
    return a;
  endfunction

  // Triangular score: n*(n+1)/2, at most 210 for n = 20.
  function automatic logic [SCORE_W-1:0] score_of(input logic [LINES_W-1:0] n);
    logic [SCORE_W-1:0] w;
    w = {{(SCORE_W-LINES_W){1'b0}}, n};
    return (w * (w + 14'd1)) >> 1;
  endfunction

endpackage

// File: rtl/row_shifter.sv
// Removes row idx from the board: rows 1..idx take the row above them and
// row 0 becomes empty. Rows below idx pass through bit-exact.
module row_shifter
  import tetris_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [BOARD_W-1:0] board_o
);

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      if (r == 0) begin : g_top
        // Row 0 always receives an empty row after a removal.
        assign board_o[ROW_W-1:0] = {ROW_W{1'b0}};
      end else begin : g_body
        // Rows at or above the removed row drop by one; others are untouched.
        assign board_o[r*ROW_W +: ROW_W] = (IDX_W'(r) <= idx_i)
                                           ? board_i[(r-1)*ROW_W +: ROW_W]
                                           : board_i[r*ROW_W +: ROW_W];
      end
    end
  endgenerate

endmodule

// File: rtl/row_clear_engine.sv
// Row-clear engine: on a lock event, scans the board bottom-up one row per
// cycle, removes full rows (retesting the same index after each removal) and
// publishes the compacted board, line count and score increment.
module row_clear_engine
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BOARD_W-1:0] board_in,
  output logic               busy,
  output logic               done,
  output logic [BOARD_W-1:0] board_out,
  output logic [LINES_W-1:0] lines_cleared,
  output logic [SCORE_W-1:0] score_add,
  output logic               top_occupied
);

  rce_state_t         state_q, state_d;
  logic [BOARD_W-1:0] work_q, work_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BOARD_W-1:0] board_out_q, board_out_d;
  logic [LINES_W-1:0] lines_cleared_q, lines_cleared_d;
  logic [SCORE_W-1:0] score_add_q, score_add_d;
  logic               top_occ_q, top_occ_d;

  logic [BOARD_W-1:0] shifted_s;
  logic [ROW_W-1:0]   cur_row_s;

  row_shifter u_row_shifter (
    .board_i (work_q),
    .idx_i   (idx_q),
    .board_o (shifted_s)
  );

  // Row currently under test.
  assign cur_row_s = work_q[row_slice(idx_q) +: ROW_W];

  // Next-state and output-register computation; every register holds by default.
  always_comb begin
    state_d         = state_q;
    work_d          = work_q;
    idx_d           = idx_q;
    lines_d         = lines_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    board_out_d     = board_out_q;
    lines_cleared_d = lines_cleared_q;
    score_add_d     = score_add_q;
    top_occ_d       = top_occ_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = board_in;
          idx_d   = IDX_W'(ROWS - 1);
          lines_d = {LINES_W{1'b0}};
          busy_d  = 1'b1;
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (row_full(cur_row_s)) begin
          // Remove the row; the row that drops into idx is retested next cycle.
          work_d = shifted_s;
          if (lines_q != LINES_W'(ROWS)) begin
            lines_d = lines_q + 5'd1;
          end else begin
            lines_d = lines_q;
          end
        end else if (idx_q == {IDX_W{1'b0}}) begin
          // Scan complete: register the results so they appear with done.
          state_d         = DONE;
          busy_d          = 1'b0;
          done_d          = 1'b1;
          board_out_d     = work_q;
          lines_cleared_d = lines_q;
          score_add_d     = score_of(lines_q);
          top_occ_d       = row_any(work_q[ROW_W-1:0]);
        end else begin
          idx_d = idx_q - 5'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      work_q          <= {BOARD_W{1'b0}};
      idx_q           <= {IDX_W{1'b0}};
      lines_q         <= {LINES_W{1'b0}};
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      board_out_q     <= {BOARD_W{1'b0}};
      lines_cleared_q <= {LINES_W{1'b0}};
      score_add_q     <= {SCORE_W{1'b0}};
      top_occ_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      work_q          <= work_d;
      idx_q           <= idx_d;
      lines_q         <= lines_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      board_out_q     <= board_out_d;
      lines_cleared_q <= lines_cleared_d;
      score_add_q     <= score_add_d;
      top_occ_q       <= top_occ_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign board_out     = board_out_q;
  assign lines_cleared = lines_cleared_q;
  assign score_add     = score_add_q;
  assign top_occupied  = top_occ_q;

endmodule

// File: tb/tb_row_clear_engine.sv
// Self-checking bench for row_clear_engine: a table of directed boards with
// hand-computed results, plus sequences for start-while-busy and mid-scan reset.
module tb_row_clear_engine;

  logic         clk;
  logic         rst;
  logic         start;
  logic [799:0] board_in;
  logic         busy;
  logic         done;
  logic [799:0] board_out;
  logic [4:0]   lines_cleared;
  logic [13:0]  score_add;
  logic         top_occupied;

  int checks;
  int errors;

  row_clear_engine dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .score_add     (score_add),
    .top_occupied  (top_occupied)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [799:0] board;
    logic [799:0] exp_board;
    logic [4:0]   exp_lines;
    logic [13:0]  exp_score;
    logic         exp_top;
    int           exp_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [799:0] put(input logic [799:0] b, input int r, input int c,
                                       input logic [3:0] v);
    b[r*40 + c*4 +: 4] = v;
    return b;
  endfunction

  function automatic logic [799:0] fill(input logic [799:0] b, input int r, input logic [3:0] v);
    for (int c = 0; c < 10; c++) b[r*40 + c*4 +: 4] = v;
    return b;
  endfunction

  task automatic chk(input string name, input logic [799:0] act, input logic [799:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Pulses start with the given board and waits for done; lat is the number of
  // edges after the start cycle at which done is seen (-1 on timeout).
  task automatic run_op(input logic [799:0] b, output int lat);
    lat = -1;
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    for (int cnt = 1; cnt <= 100; cnt++) begin
      @(posedge clk);
      #1;
      if (cnt == 1) begin
        start = 1'b0;
        chk("busy_after_start", {799'd0, busy}, 800'd1);
      end
      if (done) begin
        lat = cnt;
        break;
      end
    end
  endtask

  logic [799:0] b;
  logic [799:0] held;
  int           lat;
  int           ndone;
  int           first_done;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    board_in = 800'd0;

    // Vector table.
    b = 800'd0;
    vecs[0] = '{"empty", b, 800'd0, 5'd0, 14'd0, 1'b0, 21};

    b = fill(800'd0, 19, 4'hB);
    b = put(b, 18, 2, 4'h5);
    vecs[1] = '{"row19_colour", b, put(800'd0, 19, 2, 4'h5), 5'd1, 14'd1, 1'b0, 22};

    b = 800'd0;
    for (int r = 16; r < 20; r++) b = fill(b, r, 4'h1);
    vecs[2] = '{"rows16_19", b, 800'd0, 5'd4, 14'd10, 1'b0, 25};

    b = fill(800'd0, 19, 4'h1);
    b = fill(b, 17, 4'hF);
    b = put(b, 18, 0, 4'h3);
    b = put(b, 18, 9, 4'h9);
    vecs[3] = '{"rows19_17", b, put(put(800'd0, 19, 0, 4'h3), 19, 9, 4'h9),
                5'd2, 14'd3, 1'b0, 23};

    b = put(800'd0, 0, 4, 4'h7);
    vecs[4] = '{"top_cell", b, b, 5'd0, 14'd0, 1'b1, 21};

    b = 800'd0;
    for (int r = 0; r < 20; r++) b = fill(b, r, 4'hF);
    vecs[5] = '{"full_board", b, 800'd0, 5'd20, 14'd210, 1'b0, 41};

    b = fill(800'd0, 0, 4'h3);
    b = fill(b, 10, 4'h1);
    b = put(b, 5, 0, 4'hD);
    vecs[6] = '{"rows0_10", b, put(800'd0, 6, 0, 4'hD), 5'd2, 14'd3, 1'b0, 23};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {799'd0, busy}, 800'd0);
    chk("reset_done", {799'd0, done}, 800'd0);
    chk("reset_board", board_out, 800'd0);
    chk("reset_lines", {795'd0, lines_cleared}, 800'd0);
    chk("reset_score", {786'd0, score_add}, 800'd0);
    chk("reset_top", {799'd0, top_occupied}, 800'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].board, lat);
      chk({vecs[i].name, "_latency"}, 800'(lat), 800'(vecs[i].exp_lat));
      chk({vecs[i].name, "_busy_at_done"}, {799'd0, busy}, 800'd0);
      chk({vecs[i].name, "_board"}, board_out, vecs[i].exp_board);
      chk({vecs[i].name, "_lines"}, {795'd0, lines_cleared}, {795'd0, vecs[i].exp_lines});
      chk({vecs[i].name, "_score"}, {786'd0, score_add}, {786'd0, vecs[i].exp_score});
      chk({vecs[i].name, "_top"}, {799'd0, top_occupied}, {799'd0, vecs[i].exp_top});
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_one_cycle"}, {799'd0, done}, 800'd0);
      chk({vecs[i].name, "_hold"}, board_out, vecs[i].exp_board);
    end

    // Start pulse while busy must be ignored: exactly one done, at 21.
    b = put(800'd0, 0, 4, 4'h7);
    @(negedge clk);
    board_in   = b;
    start      = 1'b1;
    ndone      = 0;
    first_done = -1;
    for (int cnt = 1; cnt <= 45; cnt++) begin
      @(posedge clk);
      #1;
      if (cnt == 1) start = 1'b0;
      if (cnt == 4) begin
        board_in = fill(800'd0, 19, 4'h1);
        start    = 1'b1;
      end
      if (cnt == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = cnt;
      end
    end
    chk("busy_start_ndone", 800'(ndone), 800'd1);
    chk("busy_start_latency", 800'(first_done), 800'd21);
    chk("busy_start_board", board_out, b);
    chk("busy_start_top", {799'd0, top_occupied}, 800'd1);

    // Mid-scan reset: outputs clear at once, no done follows.
    b = 800'd0;
    for (int r = 15; r < 20; r++) b = fill(b, r, 4'h1);
    held = board_out;
    chk("pre_reset_board_nonzero", {799'd0, (held != 800'd0)}, 800'd1);
    @(negedge clk);
    board_in = b;
    start    = 1'b1;
    for (int cnt = 1; cnt <= 8; cnt++) begin
      @(posedge clk);
      #1;
      if (cnt == 1) start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rst_busy", {799'd0, busy}, 800'd0);
    chk("rst_board", board_out, 800'd0);
    chk("rst_top", {799'd0, top_occupied}, 800'd0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int cnt = 0; cnt < 40; cnt++) begin
      @(posedge clk);
      #1;
      if (done || busy) ndone++;
    end
    chk("rst_no_done", 800'(ndone), 800'd0);
    chk("rst_lines", {795'd0, lines_cleared}, 800'd0);
    chk("rst_score", {786'd0, score_add}, 800'd0);

    // Normal operation after reset.
    run_op(b, lat);
    chk("post_rst_latency", 800'(lat), 800'd26);
    chk("post_rst_board", board_out, 800'd0);
    chk("post_rst_lines", {795'd0, lines_cleared}, 800'd5);
    chk("post_rst_score", {786'd0, score_add}, 800'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
